axi_slave_resp_push_ctrl: RTL and testbench

Sequencer for the AXI slave read-response push path. It accepts one read-response descriptor at a time (ID, beat count, response code) and drives the shared Up_Down_Counter as a down-counting beat counter. It moves completion data beats from the first-word-fall-through completion data buffer into the R-channel response FIFO, and asserts RLAST on the final beat. It sits between the completion buffer and the response FIFO, and is the sole master of the counter's Load/En/Mode inputs.

---
 rtl/axi_slave_resp_push_ctrl.sv | 114 +++++++++++
 tb/tb_axi_slave_resp_push_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_slave_resp_push_ctrl.sv
// Read-response push sequencer: streams completion beats into the R-channel FIFO,
// using an external up/down counter as the remaining-beat counter.
module axi_slave_resp_push_ctrl #(
    parameter int DATA_WIDTH = 256,
    parameter int ID_WIDTH   = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic                  desc_valid,
    output logic                  desc_ready,
    input  logic [ID_WIDTH-1:0]   desc_id,
    input  logic [LEN_WIDTH-1:0]  desc_len,
    input  logic [1:0]            desc_resp,
    input  logic                  src_valid,
    input  logic [DATA_WIDTH-1:0] src_data,
    output logic                  src_pop,
    input  logic                  fifo_full,
    output logic                  fifo_push,
    output logic [DATA_WIDTH-1:0] push_data,
    output logic [ID_WIDTH-1:0]   push_id,
    output logic [1:0]            push_resp,
    output logic                  push_last,
    output logic                  cnt_load,
    output logic [LEN_WIDTH-1:0]  cnt_load_count,
    output logic                  cnt_en,
    output logic                  cnt_mode,
    input  logic [LEN_WIDTH-1:0]  cnt_count,
    input  logic                  cnt_done,
    output logic                  busy
);
    typedef enum logic {IDLE = 1'b0, PUSH = 1'b1} state_t;

    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic       MODE_DOWN = 1'b1;

    state_t              state;
    state_t              next_state;
    logic [ID_WIDTH-1:0] id_q;
    logic [1:0]          resp_q;
    logic                err_burst;
    logic                fire;
    logic                last_beat;
    logic                accept;

    assign err_burst  = (resp_q != RESP_OKAY);
    assign fire       = (state == PUSH) && !fifo_full && (src_valid || err_burst);
    assign last_beat  = fire && (cnt_count == '0);
    assign desc_ready = (state == IDLE) || last_beat;
    // desc_ready stays high in reset, but nothing may be accepted until release.
    assign accept     = desc_valid && desc_ready && !arst;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            id_q   <= '0;
            resp_q <= RESP_OKAY;
        end else if (accept) begin
            id_q   <= desc_id;
            resp_q <= desc_resp;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = PUSH;
            PUSH:    if (last_beat && !accept) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy           = 1'b0;
        cnt_mode       = 1'b0;
        cnt_en         = 1'b0;
        cnt_load       = 1'b0;
        cnt_load_count = '0;
        fifo_push      = 1'b0;
        src_pop        = 1'b0;
        push_last      = 1'b0;
        push_data      = '0;
        push_id        = '0;
        push_resp      = RESP_OKAY;
        if (state == PUSH) begin
            busy      = 1'b1;
            cnt_mode  = MODE_DOWN;
            cnt_en    = 1'b1;
            push_id   = id_q;
            push_resp = resp_q;
            fifo_push = fire;
            push_last = fire && cnt_done;
            // Error bursts synthesise zero data and leave the completion buffer untouched.
            src_pop   = fire && !err_burst;
            push_data = err_burst ? '0 : src_data;
            // The counter clears when En drops, so a stall holds Count by reloading it.
            if (!fire) begin
                cnt_load       = 1'b1;
                cnt_load_count = cnt_count;
            end
        end
        if (accept) begin
            cnt_load       = 1'b1;
            cnt_load_count = desc_len;
        end
    end
endmodule

// File: tb/tb_axi_slave_resp_push_ctrl.sv
// Directed bench for axi_slave_resp_push_ctrl with a behavioural model of the shared beat counter.
module tb_axi_slave_resp_push_ctrl;
    localparam int DW = 256;
    localparam int IW = 8;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          arst = 1'b1;
    logic          desc_valid, desc_ready;
    logic [IW-1:0] desc_id;
    logic [LW-1:0] desc_len;
    logic [1:0]    desc_resp;
    logic          src_valid, src_pop;
    logic [DW-1:0] src_data;
    logic          fifo_full, fifo_push;
    logic [DW-1:0] push_data;
    logic [IW-1:0] push_id;
    logic [1:0]    push_resp;
    logic          push_last, cnt_load, cnt_en, cnt_mode, cnt_done, busy;
    logic [LW-1:0] cnt_load_count, cnt_count;

    int errs = 0;
    int checks = 0;
    int sidx;
    int sbase;

    axi_slave_resp_push_ctrl #(.DATA_WIDTH(DW), .ID_WIDTH(IW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .arst(arst),
        .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_id(desc_id),
        .desc_len(desc_len), .desc_resp(desc_resp),
        .src_valid(src_valid), .src_data(src_data), .src_pop(src_pop),
        .fifo_full(fifo_full), .fifo_push(fifo_push), .push_data(push_data),
        .push_id(push_id), .push_resp(push_resp), .push_last(push_last),
        .cnt_load(cnt_load), .cnt_load_count(cnt_load_count), .cnt_en(cnt_en),
        .cnt_mode(cnt_mode), .cnt_count(cnt_count), .cnt_done(cnt_done), .busy(busy)
    );

    always #5 clk = ~clk;

    // Shared Up_Down_Counter: Load beats En, En low clears, DOWN (mode=1) saturates at 0.
    logic [LW-1:0] cnt_q;
    always_ff @(posedge clk or posedge arst) begin
        if (arst)           cnt_q <= '0;
        else if (cnt_load)  cnt_q <= cnt_load_count;
        else if (!cnt_en)   cnt_q <= '0;
        else if (cnt_mode)  cnt_q <= (cnt_q == '0) ? '0 : cnt_q - 1'b1;
        else                cnt_q <= cnt_q + 1'b1;
    end
    assign cnt_count = cnt_q;
    assign cnt_done  = cnt_en && (cnt_q == '0);

    task automatic idle_inputs();
        desc_valid = 1'b0; desc_len = '0; desc_id = '0; desc_resp = 2'b00;
        src_valid = 1'b0; src_data = '0; fifo_full = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        desc_valid = 1'b1; desc_len = 8'd4; desc_id = 8'hAA; src_valid = 1'b1; src_data = 256'h55;
        @(negedge clk); #1;
        checks++;
        if (desc_ready !== 1'b1) begin errs++; $display("FAIL reset_ready: got %0b want 1", desc_ready); end
        checks++;
        if ({busy, fifo_push, src_pop, push_last, cnt_load, cnt_en, cnt_mode} !== 7'b0) begin
            errs++; $display("FAIL reset_ctrl_outs: got %b want 0000000",
                             {busy, fifo_push, src_pop, push_last, cnt_load, cnt_en, cnt_mode});
        end
        checks++;
        if (push_data !== '0 || push_id !== '0 || push_resp !== 2'b00 || cnt_load_count !== '0) begin
            errs++; $display("FAIL reset_data_outs: got data=%0h id=%0h resp=%0b lc=%0d want all 0",
                             push_data, push_id, push_resp, cnt_load_count);
        end
        @(negedge clk);
        idle_inputs();
        arst = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || desc_ready !== 1'b1) begin
            errs++; $display("FAIL reset_no_handshake: got busy=%0b ready=%0b want 0/1", busy, desc_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_single();
        idle_inputs();
        desc_valid = 1'b1; desc_len = 8'd0; desc_id = 8'h05; src_valid = 1'b1; src_data = 256'hABCD;
        #1;
        checks++;
        if (desc_ready !== 1'b1 || cnt_load !== 1'b1 || cnt_load_count !== 8'd0 || fifo_push !== 1'b0) begin
            errs++; $display("FAIL single_accept: got ready=%0b load=%0b lc=%0d push=%0b want 1/1/0/0",
                             desc_ready, cnt_load, cnt_load_count, fifo_push);
        end
        @(negedge clk);
        desc_valid = 1'b0;
        #1;
        checks++;
        if (fifo_push !== 1'b1 || push_last !== 1'b1 || src_pop !== 1'b1 || push_id !== 8'h05 ||
            push_data !== 256'hABCD || push_resp !== 2'b00 || busy !== 1'b1) begin
            errs++; $display("FAIL single_beat: got push=%0b last=%0b pop=%0b id=%0h data=%0h want 1/1/1/5/abcd",
                             fifo_push, push_last, src_pop, push_id, push_data);
        end
        @(negedge clk);
        src_valid = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || fifo_push !== 1'b0 || desc_ready !== 1'b1) begin
            errs++; $display("FAIL single_idle: got busy=%0b push=%0b ready=%0b want 0/0/1",
                             busy, fifo_push, desc_ready);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int  cnt_exp[7];
        int  k;
        bit  exp_push;
        cnt_exp = '{3, 2, 2, 2, 2, 1, 0};
        k = 0; sidx = 0; sbase = 32'h100;
        idle_inputs();
        desc_valid = 1'b1; desc_len = 8'd3; desc_id = 8'h33; src_valid = 1'b1;
        src_data = DW'(sbase + sidx);
        #1;
        checks++;
        if (cnt_load !== 1'b1 || cnt_load_count !== 8'd3) begin
            errs++; $display("FAIL bp_accept: got load=%0b lc=%0d want 1/3", cnt_load, cnt_load_count);
        end
        @(negedge clk);
        desc_valid = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            fifo_full = (c >= 2 && c <= 4);
            src_data  = DW'(sbase + sidx);
            exp_push  = !fifo_full;
            #1;
            checks++;
            if (cnt_count !== LW'(cnt_exp[c-1])) begin
                errs++; $display("FAIL bp_count c%0d: got %0d want %0d", c, cnt_count, cnt_exp[c-1]);
            end
            checks++;
            if (fifo_push !== exp_push || src_pop !== exp_push || push_last !== (c == 7)) begin
                errs++; $display("FAIL bp_ctrl c%0d: got push=%0b pop=%0b last=%0b want %0b/%0b/%0b",
                                 c, fifo_push, src_pop, push_last, exp_push, exp_push, (c == 7));
            end
            if (exp_push) begin
                checks++;
                if (push_data !== DW'(sbase + k) || push_id !== 8'h33) begin
                    errs++; $display("FAIL bp_data c%0d: got data=%0h id=%0h want %0h/33",
                                     c, push_data, push_id, sbase + k);
                end
                k++;
            end
            if (src_pop) sidx++;
            @(negedge clk);
        end
        fifo_full = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || fifo_push !== 1'b0) begin
            errs++; $display("FAIL bp_end: got busy=%0b push=%0b want 0/0", busy, fifo_push);
        end
        @(negedge clk);
    endtask

    task automatic test_src_gaps();
        int k;
        int pops;
        bit exp_push;
        k = 0; pops = 0; sidx = 0; sbase = 32'h2000;
        idle_inputs();
        desc_valid = 1'b1; desc_len = 8'd7; desc_id = 8'h77; src_valid = 1'b1;
        src_data = DW'(sbase + sidx);
        @(negedge clk);
        desc_valid = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            src_valid = (c % 2 == 1);
            src_data  = DW'(sbase + sidx);
            exp_push  = (c % 2 == 1) && (c <= 15);
            #1;
            checks++;
            if (fifo_push !== exp_push || src_pop !== exp_push || busy !== (c <= 15)) begin
                errs++; $display("FAIL gaps_ctrl c%0d: got push=%0b pop=%0b busy=%0b want %0b/%0b/%0b",
                                 c, fifo_push, src_pop, busy, exp_push, exp_push, (c <= 15));
            end
            if (exp_push) begin
                checks++;
                if (push_data !== DW'(sbase + k) || push_last !== (k == 7) || push_id !== 8'h77) begin
                    errs++; $display("FAIL gaps_beat %0d: got data=%0h last=%0b id=%0h want %0h/%0b/77",
                                     k, push_data, push_last, push_id, sbase + k, (k == 7));
                end
                k++;
            end
            if (src_pop) begin sidx++; pops++; end
            @(negedge clk);
        end
        checks++;
        if (pops !== 8) begin errs++; $display("FAIL gaps_pops: got %0d want 8", pops); end
        src_valid = 1'b0;
    endtask

    task automatic test_back_to_back();
        int  cnt_exp[5];
        int  k;
        bit  exp_push;
        bit  exp_last;
        logic [IW-1:0] exp_id;
        cnt_exp = '{1, 0, 2, 1, 0};
        k = 0; sidx = 0; sbase = 32'h300;
        idle_inputs();
        desc_valid = 1'b1; desc_len = 8'd1; desc_id = 8'h01; src_valid = 1'b1;
        src_data = DW'(sbase + sidx);
        #1;
        checks++;
        if (cnt_load !== 1'b1 || cnt_load_count !== 8'd1) begin
            errs++; $display("FAIL b2b_accept_a: got load=%0b lc=%0d want 1/1", cnt_load, cnt_load_count);
        end
        @(negedge clk);
        for (int c = 1; c <= 6; c++) begin
            desc_valid = (c <= 2); desc_len = 8'd2; desc_id = 8'h02;
            src_data   = DW'(sbase + sidx);
            exp_push   = (c <= 5);
            exp_last   = (c == 2) || (c == 5);
            exp_id     = (c <= 2) ? 8'h01 : 8'h02;
            #1;
            checks++;
            if (fifo_push !== exp_push || push_last !== exp_last) begin
                errs++; $display("FAIL b2b_ctrl c%0d: got push=%0b last=%0b want %0b/%0b",
                                 c, fifo_push, push_last, exp_push, exp_last);
            end
            if (exp_push) begin
                checks++;
                if (push_id !== exp_id || push_data !== DW'(sbase + k) || cnt_count !== LW'(cnt_exp[c-1])) begin
                    errs++; $display("FAIL b2b_beat c%0d: got id=%0h data=%0h cnt=%0d want %0h/%0h/%0d",
                                     c, push_id, push_data, cnt_count, exp_id, sbase + k, cnt_exp[c-1]);
                end
                k++;
            end
            if (c == 1) begin
                checks++;
                if (desc_ready !== 1'b0) begin errs++; $display("FAIL b2b_ready_mid: got %0b want 0", desc_ready); end
            end
            if (c == 2) begin
                checks++;
                if (desc_ready !== 1'b1 || cnt_load !== 1'b1 || cnt_load_count !== 8'd2) begin
                    errs++; $display("FAIL b2b_handover: got ready=%0b load=%0b lc=%0d want 1/1/2",
                                     desc_ready, cnt_load, cnt_load_count);
                end
            end
            if (c == 6) begin
                checks++;
                if (busy !== 1'b0) begin errs++; $display("FAIL b2b_end: got busy=%0b want 0", busy); end
            end
            if (src_pop) sidx++;
            @(negedge clk);
        end
        idle_inputs();
    endtask

    task automatic test_error_burst();
        idle_inputs();
        desc_valid = 1'b1; desc_len = 8'd2; desc_id = 8'h44; desc_resp = 2'b10;
        src_valid = 1'b0; src_data = 256'hDEADBEEF;
        @(negedge clk);
        desc_valid = 1'b0; desc_resp = 2'b00;
        for (int c = 1; c <= 4; c++) begin
            #1;
            if (c <= 3) begin
                checks++;
                if (fifo_push !== 1'b1 || push_data !== '0 || push_resp !== 2'b10 || src_pop !== 1'b0 ||
                    push_last !== (c == 3) || push_id !== 8'h44 || cnt_count !== LW'(3 - c)) begin
                    errs++; $display("FAIL err_beat c%0d: got push=%0b data=%0h resp=%0b pop=%0b last=%0b cnt=%0d want 1/0/10/0/%0b/%0d",
                                     c, fifo_push, push_data, push_resp, src_pop, push_last, cnt_count, (c == 3), 3 - c);
                end
            end else begin
                checks++;
                if (busy !== 1'b0 || fifo_push !== 1'b0) begin
                    errs++; $display("FAIL err_end: got busy=%0b push=%0b want 0/0", busy, fifo_push);
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_burst();
        idle_inputs();
        desc_valid = 1'b1; desc_len = 8'd15; desc_id = 8'h0F; src_valid = 1'b1; src_data = 256'h11;
        @(negedge clk);
        desc_valid = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            #1;
            checks++;
            if (fifo_push !== 1'b1 || cnt_count !== LW'(16 - c)) begin
                errs++; $display("FAIL rst_pre c%0d: got push=%0b cnt=%0d want 1/%0d", c, fifo_push, cnt_count, 16 - c);
            end
            @(negedge clk);
        end
        arst = 1'b1;
        desc_valid = 1'b1; desc_len = 8'd0; desc_id = 8'h22;
        #1;
        checks++;
        if (fifo_push !== 1'b0 || desc_ready !== 1'b1 || busy !== 1'b0 || src_pop !== 1'b0 || cnt_load !== 1'b0) begin
            errs++; $display("FAIL rst_abort: got push=%0b ready=%0b busy=%0b pop=%0b load=%0b want 0/1/0/0/0",
                             fifo_push, desc_ready, busy, src_pop, cnt_load);
        end
        @(negedge clk); #1;
        checks++;
        if (cnt_count !== '0 || busy !== 1'b0 || fifo_push !== 1'b0) begin
            errs++; $display("FAIL rst_hold: got cnt=%0d busy=%0b push=%0b want 0/0/0", cnt_count, busy, fifo_push);
        end
        @(negedge clk);
        arst = 1'b0;
        src_data = 256'h9999;
        #1;
        checks++;
        if (cnt_load !== 1'b1 || cnt_load_count !== 8'd0 || desc_ready !== 1'b1) begin
            errs++; $display("FAIL rst_new_accept: got load=%0b lc=%0d ready=%0b want 1/0/1",
                             cnt_load, cnt_load_count, desc_ready);
        end
        @(negedge clk);
        desc_valid = 1'b0;
        #1;
        checks++;
        if (fifo_push !== 1'b1 || push_last !== 1'b1 || push_id !== 8'h22 || push_data !== 256'h9999) begin
            errs++; $display("FAIL rst_new_beat: got push=%0b last=%0b id=%0h data=%0h want 1/1/22/9999",
                             fifo_push, push_last, push_id, push_data);
        end
        @(negedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin errs++; $display("FAIL rst_new_end: got busy=%0b want 0", busy); end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_src_gaps();
        test_back_to_back();
        test_error_burst();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
